// File: rtl/mem_ram_ctrl.sv
// Data-RAM access sequencer for the MEM stage: one load/store at a time over a req/ack RAM port,
// read-modify-write for partial stores, and a bounded wait per RAM phase that reports a timeout.
module mem_ram_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3:0]            req_be_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic                  ram_ack_i,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-3:0]   waddr_q, waddr_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    timeout_hit;
  logic                    unused_addr_lsb;

  // The byte offset only matters to the MEM stage's extract/extend logic.
  assign unused_addr_lsb = ^req_addr_i[1:0];

  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_rdata_i[8*i +: 8];
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          waddr_d = req_addr_i[ADDR_WIDTH-1:2];
          we_d    = req_we_i;
          be_d    = req_be_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!req_we_i)              state_d = S_RD;
          else if (req_be_i == 4'hF)  state_d = S_WR;
          else if (req_be_i == 4'h0)  state_d = S_DONE;
          else                        state_d = S_RD;
        end
      end
      S_RD: begin
        if (ram_ack_i) begin
          cnt_d = '0;
          if (!we_q) begin
            rdata_d = ram_rdata_i;
            state_d = S_DONE;
          end else begin
            // The merged word replaces the store data so WR drives it unchanged.
            wdata_d = merged;
            state_d = S_WR;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR: begin
        if (ram_ack_i) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshakes: MEM access transfers on a cycle with req_valid_i && req_ready_o; a RAM phase
  // holds req/we/addr/wdata stable from registers until the cycle ram_ack_i is seen high.
  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign ram_req_o   = (state_q == S_RD) || (state_q == S_WR);
  assign ram_we_o    = (state_q == S_WR);
  assign ram_addr_o  = {waddr_q, 2'b00};
  assign ram_wdata_o = wdata_q;
  assign rsp_valid_o = (state_q == S_DONE);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// Bench for mem_ram_ctrl: a word-addressed RAM responder with programmable ack delay, and a
// reference model that predicts response, latency, RAM traffic and final memory per access.
module tb_mem_ram_ctrl;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o, rsp_err_o, busy_o;
  logic [31:0] rsp_rdata_o;
  logic        ram_req_o, ram_we_o, ram_ack_i;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_ram_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i)
  );

  // ---------------- RAM model ----------------
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    case (a[31:2])
      30'h41:  return 32'hDEADBEEF;
      30'h80:  return 32'h11223344;
      default: return {a[31:2], 2'b00} ^ 32'h5A5AC3C3;
    endcase
  endfunction

  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          in_phase = 0;
  int          n_rd = 0, n_wr = 0, req_cycles = 0, we_cycles = 0, addr_bad = 0, unstable = 0;
  logic [31:0] ph_addr, ph_wdata, last_addr;
  logic        ph_we;

  always @(negedge clk) begin
    ram_ack_i   = 1'b0;
    ram_rdata_i = $urandom();
    if (ram_req_o) begin
      req_cycles++;
      if (ram_we_o) we_cycles++;
      if (ram_addr_o[1:0] != 2'b00) addr_bad++;
      last_addr = ram_addr_o;
      if (!in_phase) begin
        in_phase = 1;
        wait_cnt = 0;
        ph_addr  = ram_addr_o;
        ph_we    = ram_we_o;
        ph_wdata = ram_wdata_o;
      end else if (ram_addr_o !== ph_addr || ram_we_o !== ph_we ||
                   (ph_we && ram_wdata_o !== ph_wdata)) begin
        unstable++;
      end
      if (ack_delay >= 0 && wait_cnt == ack_delay) begin
        ram_ack_i = 1'b1;
        in_phase  = 0;
        if (ram_we_o) begin
          mem[ram_addr_o[31:2]] = ram_wdata_o;
          n_wr++;
        end else begin
          ram_rdata_i = mem_rd(ram_addr_o);
          n_rd++;
        end
      end
      wait_cnt++;
    end else begin
      in_phase = 0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access end to end; expectations come from the access type, the ack delay and the
  // memory contents before the access.
  task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata, input int delay);
    logic [31:0] pre, merged, exp_mem, exp_rdata;
    int phases, exp_lat, exp_rd_n, exp_wr_n, exp_req, exp_we, lat, busy_n, guard;
    int b_rd, b_wr, b_req, b_we, b_bad, b_uns;
    bit tmo;
    logic exp_err;
    pre = mem_rd(addr);
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : pre[8*i +: 8];
    if (!we) phases = 1;
    else if (be == 4'h0) phases = 0;
    else if (be == 4'hF) phases = 1;
    else phases = 2;
    tmo = (delay < 0) && (phases > 0);
    if (tmo) begin
      exp_lat = 1 + T; exp_rd_n = 0; exp_wr_n = 0; exp_req = T;
      exp_we = (we && be == 4'hF) ? T : 0;
      exp_mem = pre; exp_rdata = 32'h0; exp_err = 1'b1;
    end else begin
      exp_lat  = 1 + phases * (delay + 1);
      exp_rd_n = (!we || phases == 2) ? 1 : 0;
      exp_wr_n = (we && phases > 0) ? 1 : 0;
      exp_req  = phases * (delay + 1);
      exp_we   = exp_wr_n * (delay + 1);
      exp_mem  = we ? merged : pre;
      exp_rdata = we ? 32'h0 : pre;
      exp_err  = 1'b0;
    end
    exp_q.push_back(exp_rdata);
    ack_delay = delay;
    b_rd = n_rd; b_wr = n_wr; b_req = req_cycles; b_we = we_cycles; b_bad = addr_bad; b_uns = unstable;

    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_be_i = be; req_wdata_i = wdata;
    guard = 0;
    while (!req_ready_o && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0; req_we_i = $urandom_range(0, 1); req_addr_i = $urandom();
    req_be_i = 4'($urandom()); req_wdata_i = $urandom();
    lat = 1; busy_n = 0;
    while (!rsp_valid_o && lat < 200) begin
      if (busy_o) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (busy_o) busy_n++;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    check({tag, " rdata"}, rsp_rdata_o, exp_q.pop_front());
    check({tag, " err"}, 32'(rsp_err_o), 32'(exp_err));
    check({tag, " ready_in_done"}, 32'(req_ready_o), 32'd0);
    check({tag, " ram_reads"}, 32'(n_rd - b_rd), 32'(exp_rd_n));
    check({tag, " ram_writes"}, 32'(n_wr - b_wr), 32'(exp_wr_n));
    check({tag, " req_cycles"}, 32'(req_cycles - b_req), 32'(exp_req));
    check({tag, " we_cycles"}, 32'(we_cycles - b_we), 32'(exp_we));
    check({tag, " stable_aligned"}, 32'((addr_bad - b_bad) + (unstable - b_uns)), 32'd0);
    if (exp_req > 0) check({tag, " ram_addr"}, last_addr, {addr[31:2], 2'b00});
    check({tag, " mem"}, mem_rd(addr), exp_mem);
    @(negedge clk);
    check({tag, " pulse_end"}, 32'(rsp_valid_o), 32'd0);
    check({tag, " idle_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pre_l, pre_s, exp_s, w;
    int lat, guard, pulses, r, dly;
    rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_be_i = '0; req_wdata_i = '0;
    #2;
    check("reset ready", 32'(req_ready_o), 32'd1);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset ram_req", 32'(ram_req_o), 32'd0);
    check("reset ram_we", 32'(ram_we_o), 32'd0);
    check("reset ram_addr", ram_addr_o, 32'd0);
    check("reset ram_wdata", ram_wdata_o, 32'd0);
    check("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset rsp_rdata", rsp_rdata_o, 32'd0);
    check("reset rsp_err", 32'(rsp_err_o), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_access("load_104", 1'b0, 32'h104, 4'h0, 32'h0, 3);
    do_access("sb_201", 1'b1, 32'h201, 4'b0010, 32'h0000AB00, 0);
    check("sb_201 word", mem_rd(32'h200), 32'h1122AB44);
    do_access("sw_full", 1'b1, 32'h208, 4'hF, 32'hCAFEF00D, 0);
    check("sw_full word", mem_rd(32'h208), 32'hCAFEF00D);
    do_access("store_be0", 1'b1, 32'h20C, 4'h0, 32'hFFFFFFFF, 0);
    do_access("load_tmo", 1'b0, 32'h104, 4'h0, 32'h0, -1);
    do_access("rmw_tmo", 1'b1, 32'h210, 4'b0101, 32'h00FF00FF, -1);
    do_access("sw_tmo", 1'b1, 32'h214, 4'hF, 32'h12345678, -1);
    do_access("load_ack_last", 1'b0, 32'h208, 4'h0, 32'h0, T - 1);
    do_access("rmw_ack_last", 1'b1, 32'h218, 4'b1000, 32'h77000000, T - 1);

    // Reset while a write phase is outstanding.
    ack_delay = -1;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h300; req_be_i = 4'hF;
    req_wdata_i = 32'h13572468;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rst_wr in_write", 32'(ram_we_o), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr ram_req", 32'(ram_req_o), 32'd0);
    check("rst_wr ram_we", 32'(ram_we_o), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_o) pulses++;
    end
    check("rst_wr no_rsp", 32'(pulses), 32'd0);
    check("rst_wr ready", 32'(req_ready_o), 32'd1);
    check("rst_wr mem", mem_rd(32'h300), 32'h13572468 ^ 32'h13572468 ^ (32'h300 ^ 32'h5A5AC3C3));

    // Back-to-back: load then SH with req_valid_i held high throughout.
    ack_delay = 0;
    w = $urandom();
    pre_l = mem_rd(32'h40);
    pre_s = mem_rd(32'h44);
    exp_s = {w[31:16], pre_s[15:0]};
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h40; req_be_i = 4'h0; req_wdata_i = 32'h0;
    @(negedge clk);
    req_we_i = 1'b1; req_addr_i = 32'h46; req_be_i = 4'b1100; req_wdata_i = w;
    check("b2b ready_rd", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    check("b2b load valid", 32'(rsp_valid_o), 32'd1);
    check("b2b load rdata", rsp_rdata_o, pre_l);
    check("b2b ready_done", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    check("b2b ready_idle", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 1; guard = 0;
    while (!rsp_valid_o && guard < 200) begin
      @(negedge clk);
      lat++; guard++;
    end
    check("b2b sh latency", 32'(lat), 32'd3);
    check("b2b sh rdata", rsp_rdata_o, 32'h0);
    check("b2b sh err", 32'(rsp_err_o), 32'd0);
    check("b2b sh mem", mem_rd(32'h44), exp_s);
    @(negedge clk);

    // Randomized accesses over a small address window so words get revisited.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) dly = -1;
      else if (r == 1) dly = T - 1;
      else dly = $urandom_range(0, 3);
      do_access($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                4'($urandom()), $urandom(), dly);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
